femto_uart_bus_master: RTL
==========================

// Module: femto_uart_bus_master
// PURPOSE
//  Serial debug/loader bridge; bus initiator on the femtorv32-style memory bus, the opposite role to the SoC's RAM/IO responder.
//  Consumes command bytes from a byte-level UART interface and issues word reads/writes on mem_* (RAM or IO page).
//  Requests the bus via bus_req/bus_gnt; external arbitration stalls the CPU while granted.
// PARAMETERS
//  ADDR_WIDTH  24  width of mem_addr; upper received address bits dropped
//  BUS_WAIT    2   cycles after a strobe before mem_rbusy/mem_wbusy are trusted (covers registered busy)
//  TX_GUARD    1   cycles after a tx_valid pulse before tx_busy is trusted
// PORTS
//  clk        in   1           system clock
//  reset      in   1           asynchronous, active-high reset
//  rx_data    in   8           received byte
//  rx_valid   in   1           one-cycle pulse: rx_data valid
//  tx_data    out  8           byte to transmit
//  tx_valid   out  1           one-cycle pulse: send tx_data
//  tx_busy    in   1           transmitter busy
//  bus_req    out  1           bridge requests the memory bus
//  bus_gnt    in   1           bus granted to bridge
//  mem_addr   out  ADDR_WIDTH  byte address, bits[1:0] always 0
//  mem_wdata  out  32          write data
//  mem_wmask  out  4           write byte mask; 4'b1111 for one cycle = write strobe
//  mem_rstrb  out  1           one-cycle read strobe
//  mem_rdata  in   32          read data
//  mem_rbusy  in   1           read in progress
//  mem_wbusy  in   1           write in progress
// BEHAVIOUR
//  Reset: state IDLE; tx_valid, bus_req, mem_rstrb = 0; mem_wmask = 0; tx_data, mem_addr, mem_wdata = 0; addr/data regs 0.
//  Commands (multi-byte fields little-endian):
//   'W'(0x57) + 4 addr + 4 data -> word write, then reply 'K'(0x4B)
//   'R'(0x52) + 4 addr          -> word read, reply 4 data bytes, LSB first
//   other byte in IDLE          -> reply '?'(0x3F), stay command-ready
//  States: IDLE -> GET_ADDR -> (GET_DATA if W) -> WAIT_GNT -> STROBE -> WAIT_BUS -> SEND -> IDLE.
//   IDLE: on rx_valid decode command byte; byte counter cleared.
//   GET_ADDR/GET_DATA: shift one byte per rx_valid; advance after 4th byte.
//   WAIT_GNT: bus_req=1 (held through WAIT_BUS); on first cycle bus_gnt=1 -> STROBE.
//   STROBE: exactly one cycle of mem_wmask=4'b1111 (W) or mem_rstrb=1 (R); mem_addr/mem_wdata stable from STROBE to end of WAIT_BUS.
//   WAIT_BUS: count BUS_WAIT cycles, then leave on first cycle busy=0 (rbusy for R, wbusy for W); R latches mem_rdata that cycle.
//    With BUS_WAIT=2 and zero-wait RAM: strobe at cycle t, data captured at t+2.
//   Leaving WAIT_BUS: bus_req deasserts the next cycle; -> SEND.
//   SEND: per byte wait tx_busy=0 (after TX_GUARD cycles since last pulse), pulse tx_valid one cycle with tx_data; 1 byte (K/?) or 4 (R).
//  bus_gnt dropping mid-transaction is ignored; bridge finishes its strobe/wait (arbiter holds grant while bus_req=1).
//  rx_valid outside IDLE/GET_ADDR/GET_DATA: byte silently dropped; no queueing.
//  mem_addr = {recv_addr[ADDR_WIDTH-1:2],2'b00}; unaligned address bits ignored, not errored.
//  Simultaneous rx_valid and SEND completion: byte dropped (SEND->IDLE takes effect next cycle).
//  reset mid-operation: immediate return to reset values; any partial command discarded, no reply.
// CONFIGURATION
//  FEMTO_BUS_MASTER_AUTOINC_EN defined: address reg += 4 after every completed R/W (wraps modulo 2^ADDR_WIDTH);
//   'w'(0x77)+4 data and 'r'(0x72) reuse stored address (skip GET_ADDR).
//  Undefined: no increment; 'w'/'r' are unknown commands -> reply '?'.
// TESTING
//  1. 'W',00 10 00 00,EF BE AD DE; RAM model -> one cycle mem_wmask=F, addr 0x001000, wdata 0xDEADBEEF; reply 0x4B.
//  2. 'R',00 10 00 00 after test 1 -> one mem_rstrb at 0x001000; reply EF,BE,AD,DE in order, one tx_valid per byte.
//  3. bus_gnt held 0 for 50 cycles after 'R'+addr -> bus_req=1, no strobe until gnt; then normal read; bus_req low after WAIT_BUS.
//  4. 'R' to 0x400010 with mem_rbusy=1 for 10 cycles -> rdata captured on first rbusy=0 after BUS_WAIT; 0x55 sent during wait is dropped.
//  5. byte 0x41 -> reply 0x3F; reset asserted after 2 addr bytes of 'W' -> all outputs 0; next 'R' decodes as a fresh command.
//  6. AUTOINC_EN: 'W' @0xFFFFFC then 'w' -> second write at 0x000000 (wrap); without macro, 'w' -> 0x3F.

Source files
------------

// File: rtl/femto_uart_bus_master.sv
// UART-driven bus initiator: 'W'/'R' byte commands become word writes/reads on the femtorv32-style mem_* bus.
// Optional FEMTO_BUS_MASTER_AUTOINC_EN: post-increment address and accept 'w'/'r' commands that reuse it.
module femto_uart_bus_master #(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned BUS_WAIT   = 2,
    parameter int unsigned TX_GUARD   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_busy,
    output logic                  bus_req,
    input  logic                  bus_gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wmask,
    output logic                  mem_rstrb,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_rbusy,
    input  logic                  mem_wbusy
);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] REPLY_OK  = 8'h4B;
    localparam logic [7:0] REPLY_ERR = 8'h3F;
`ifdef FEMTO_BUS_MASTER_AUTOINC_EN
    localparam logic [7:0] CMD_WRITE_INC = 8'h77;
    localparam logic [7:0] CMD_READ_INC  = 8'h72;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_WAIT_GNT,
        S_STROBE,
        S_WAIT_BUS,
        S_SEND
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [7:0]            wait_q, wait_d;
    logic [7:0]            guard_q, guard_d;
    logic [2:0]            rem_q, rem_d;
    logic                  is_wr_q, is_wr_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  bus_req_q, bus_req_d;
    logic                  rstrb_q, rstrb_d;
    logic [3:0]            wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  unused_addr_bits;
`ifdef FEMTO_BUS_MASTER_AUTOINC_EN
    logic [ADDR_WIDTH-1:0] addr_inc;
    assign addr_inc = addr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(4);
`endif

    // Received address bits outside the bus window are intentionally dropped
    assign unused_addr_bits = ^addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            wait_q     <= '0;
            guard_q    <= '0;
            rem_q      <= '0;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            bus_req_q  <= 1'b0;
            rstrb_q    <= 1'b0;
            wmask_q    <= '0;
            maddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            wait_q     <= wait_d;
            guard_q    <= guard_d;
            rem_q      <= rem_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            bus_req_q  <= bus_req_d;
            rstrb_q    <= rstrb_d;
            wmask_q    <= wmask_d;
            maddr_q    <= maddr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        wait_d     = wait_q;
        guard_d    = (guard_q != 8'd0) ? guard_q - 8'd1 : 8'd0;
        rem_d      = rem_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        bus_req_d  = bus_req_q;
        rstrb_d    = 1'b0;
        wmask_d    = 4'b0000;
        maddr_d    = maddr_q;
        wdata_d    = wdata_q;

        case (state_q)
            S_IDLE: begin
                byte_cnt_d = 2'd0;
                if (rx_valid) begin
                    case (rx_data)
                        CMD_WRITE: begin
                            is_wr_d = 1'b1;
                            state_d = S_GET_ADDR;
                        end
                        CMD_READ: begin
                            is_wr_d = 1'b0;
                            state_d = S_GET_ADDR;
                        end
`ifdef FEMTO_BUS_MASTER_AUTOINC_EN
                        CMD_WRITE_INC: begin
                            is_wr_d = 1'b1;
                            state_d = S_GET_DATA;
                        end
                        CMD_READ_INC: begin
                            is_wr_d   = 1'b0;
                            bus_req_d = 1'b1;
                            state_d   = S_WAIT_GNT;
                        end
`endif
                        default: begin
                            data_d  = {24'h0, REPLY_ERR};
                            rem_d   = 3'd1;
                            state_d = S_SEND;
                        end
                    endcase
                end
            end

            // Little-endian: each new byte enters at the top and shifts down
            S_GET_ADDR: begin
                if (rx_valid) begin
                    addr_d     = {rx_data, addr_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (is_wr_q) begin
                            state_d = S_GET_DATA;
                        end else begin
                            bus_req_d = 1'b1;
                            state_d   = S_WAIT_GNT;
                        end
                    end
                end
            end

            S_GET_DATA: begin
                if (rx_valid) begin
                    data_d     = {rx_data, data_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        bus_req_d = 1'b1;
                        state_d   = S_WAIT_GNT;
                    end
                end
            end

            S_WAIT_GNT: begin
                if (bus_gnt) begin
                    maddr_d = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                    wdata_d = data_q;
                    if (is_wr_q) begin
                        wmask_d = 4'b1111;
                    end else begin
                        rstrb_d = 1'b1;
                    end
                    state_d = S_STROBE;
                end
            end

            S_STROBE: begin
                wait_d  = 8'd1;
                state_d = S_WAIT_BUS;
            end

            // Busy flags are only meaningful BUS_WAIT cycles after the strobe
            S_WAIT_BUS: begin
                if (wait_q < 8'(BUS_WAIT)) begin
                    wait_d = wait_q + 8'd1;
                end else if (is_wr_q ? !mem_wbusy : !mem_rbusy) begin
                    bus_req_d = 1'b0;
                    state_d   = S_SEND;
                    if (is_wr_q) begin
                        data_d = {24'h0, REPLY_OK};
                        rem_d  = 3'd1;
                    end else begin
                        data_d = mem_rdata;
                        rem_d  = 3'd4;
                    end
`ifdef FEMTO_BUS_MASTER_AUTOINC_EN
                    addr_d = 32'(addr_inc);
`endif
                end
            end

            S_SEND: begin
                if (guard_q == 8'd0 && !tx_busy) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = data_q[7:0];
                    data_d     = {8'h0, data_q[31:8]};
                    rem_d      = rem_q - 3'd1;
                    guard_d    = 8'(TX_GUARD);
                    if (rem_q == 3'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign bus_req   = bus_req_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign mem_rstrb = rstrb_q;

endmodule
